phy_rx_deser: RTL



---
 rtl/phy_pkg.sv | 13 +
 rtl/phy_rx_com_det.sv | 26 ++
 rtl/phy_rx_deser.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared constants and state type for the PHY lane receive path.
package phy_pkg;

    localparam logic [7:0]  PHY_COM    = 8'hBC;
    localparam int unsigned PHY_BYTE_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } phy_rx_state_e;

endpackage

// File: rtl/phy_rx_com_det.sv
// Serial shift register with look-ahead COM detection.
// o_sr_next is the byte window including the bit being sampled this cycle.
module phy_rx_com_det
    import phy_pkg::*;
#(
    parameter logic [7:0] COM_BYTE = PHY_COM
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_data,
    output logic [PHY_BYTE_W-1:0] o_sr_next,
    output logic                  o_com_hit
);

    logic [PHY_BYTE_W-1:0] r_sr;

    assign o_sr_next = {r_sr[PHY_BYTE_W-2:0], i_data};
    assign o_com_hit = (o_sr_next == COM_BYTE);

    // Shift one lane bit in per clock, MSB of each byte first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sr <= '0;
        else          r_sr <= o_sr_next;
    end

endmodule

// File: rtl/phy_rx_deser.sv
// Receive-side lane deserializer: finds COM alignment, locks after
// LOCK_COMS aligned COMs, then emits one byte every 8 bit clocks.
// Optional macro PHY_RX_COM_CNT_EN adds a saturating COM counter output.
module phy_rx_deser
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM_BYTE  = PHY_COM,
    parameter int unsigned LOCK_COMS = 4
) (
    input  logic        clk32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        byte_stb,
    output logic        active
`ifdef PHY_RX_COM_CNT_EN
    ,
    output logic [15:0] com_count
`endif
);

    localparam logic [4:0] LP_LOCK = LOCK_COMS[4:0];

    phy_rx_state_e         r_state;
    phy_rx_state_e         w_state_next;
    logic [2:0]            r_bit_cnt;
    logic [3:0]            r_com_cnt;
    logic [PHY_BYTE_W-1:0] w_sr_next;
    logic                  w_com_hit;
    logic                  w_boundary;
    logic                  w_lock;
    logic                  w_out_load;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_stb;

    phy_rx_com_det #(
        .COM_BYTE (COM_BYTE)
    ) u_com_det (
        .i_clk     (clk32f),
        .i_rst_n   (reset),
        .i_data    (data_in),
        .o_sr_next (w_sr_next),
        .o_com_hit (w_com_hit)
    );

    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_lock     = w_com_hit && (({1'b0, r_com_cnt} + 5'd1) == LP_LOCK);

    // State register.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) r_state <= SEARCH;
        else        r_state <= w_state_next;
    end

    // Next-state: hunt for COM, confirm at byte boundaries, then stay locked.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH: if (w_com_hit) w_state_next = ALIGN;
            ALIGN: begin
                if (w_boundary) begin
                    if (!w_com_hit)  w_state_next = SEARCH;
                    else if (w_lock) w_state_next = ACTIVE;
                end
            end
            ACTIVE:  w_state_next = ACTIVE;
            default: w_state_next = SEARCH;
        endcase
    end

    // Output decode: the locking boundary already publishes its COM byte.
    always_comb begin
        w_out_load = 1'b0;
        case (r_state)
            ALIGN:   w_out_load = w_boundary && w_lock;
            ACTIVE:  w_out_load = w_boundary;
            default: w_out_load = 1'b0;
        endcase
    end

    // Bit phase and aligned-COM run counters.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_com_cnt <= '0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_com_hit) begin
                        r_bit_cnt <= '0;
                        r_com_cnt <= 4'd1;
                    end
                end
                ALIGN: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_com_hit) r_com_cnt <= r_com_cnt + 4'd1;
                        else           r_com_cnt <= '0;
                    end
                end
                ACTIVE:  r_bit_cnt <= r_bit_cnt + 3'd1;
                default: r_bit_cnt <= r_bit_cnt;
            endcase
        end
    end

    // Byte output registers, updated on the edge sampling the last bit.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_stb   <= 1'b0;
        end else if (w_out_load) begin
            r_data  <= w_sr_next;
            r_valid <= !w_com_hit;
            r_stb   <= 1'b1;
        end else begin
            r_stb   <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign byte_stb  = r_stb;
    assign active    = (r_state == ACTIVE);

`ifdef PHY_RX_COM_CNT_EN
    logic [15:0] r_com_count;

    // Count COM bytes seen at locked boundaries, saturating.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            r_com_count <= '0;
        end else if (w_out_load && w_com_hit && (r_com_count != '1)) begin
            r_com_count <= r_com_count + 16'd1;
        end
    end

    assign com_count = r_com_count;
`endif

endmodule
